// File: rtl/main_ctrl_fsm.sv
// main_ctrl_fsm: multicycle MIPS main control FSM.
// Decodes Opcode and sequences each instruction through fetch / decode / execute /
// memory / writeback, driving the datapath strobes and mux selects as Moore outputs.
//
// Ports:
//   clk          system clock, all state on rising edge
//   rst          synchronous active-high reset; forces every output to 0 while high
//   Opcode[5:0]  instr[31:26] from IR, valid from DECODE onward
//   JR           jr flag from ALU control, only looked at in EXEC
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
//   AluSrcA, AluSrcB[1:0], AluOp[1:0], PCSource[1:0]   datapath controls
//   State[3:0]   current state code (reads 0 while rst is high)
module main_ctrl_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'd0,
  parameter logic [5:0] OP_LW    = 6'd35,
  parameter logic [5:0] OP_SW    = 6'd43,
  parameter logic [5:0] OP_BEQ   = 6'd4,
  parameter logic [5:0] OP_J     = 6'd2,
  parameter logic [5:0] OP_ORI   = 6'd13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Opcode,
  input  logic       JR,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [1:0] AluOp,
  output logic [1:0] PCSource,
  output logic [3:0] State
);

  localparam logic [3:0] StFetch  = 4'd0;
  localparam logic [3:0] StDecode = 4'd1;
  localparam logic [3:0] StMemAdr = 4'd2;
  localparam logic [3:0] StMemRd  = 4'd3;
  localparam logic [3:0] StMemWb  = 4'd4;
  localparam logic [3:0] StMemWr  = 4'd5;
  localparam logic [3:0] StExec   = 4'd6;
  localparam logic [3:0] StRwb    = 4'd7;
  localparam logic [3:0] StBranch = 4'd8;
  localparam logic [3:0] StJump   = 4'd9;
  localparam logic [3:0] StOriEx  = 4'd10;
  localparam logic [3:0] StOriWb  = 4'd11;
  localparam logic [3:0] StJreg   = 4'd12;

  logic [3:0] state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        if (Opcode == OP_LW || Opcode == OP_SW) state_d = StMemAdr;
        else if (Opcode == OP_RTYPE)            state_d = StExec;
        else if (Opcode == OP_BEQ)              state_d = StBranch;
        else if (Opcode == OP_J)                state_d = StJump;
        else if (Opcode == OP_ORI)              state_d = StOriEx;
        else                                    state_d = StFetch;  // unknown op: nop
      end
      StMemAdr: begin
        if (Opcode == OP_LW)      state_d = StMemRd;
        else if (Opcode == OP_SW) state_d = StMemWr;
        else                      state_d = StFetch;
      end
      StMemRd:  state_d = StMemWb;
      StExec:   state_d = JR ? StJreg : StRwb;
      StOriEx:  state_d = StOriWb;
      // MEMWB, MEMWR, RWB, BRANCH, JUMP, ORIWB, JREG and unused codes return to fetch
      default:  state_d = StFetch;
    endcase
  end

  // Moore outputs; everything is held at 0 while rst is high so a reset
  // mid-instruction suppresses that cycle's strobes.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    AluSrcA     = 1'b0;
    AluSrcB     = 2'b00;
    AluOp       = 2'b00;
    PCSource    = 2'b00;
    State       = 4'd0;
    if (!rst) begin
      State = state_q;
      case (state_q)
        StFetch: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          AluSrcB = 2'b01;
        end
        StDecode: AluSrcB = 2'b11;  // branch target precompute
        StMemAdr: begin
          AluSrcA = 1'b1;
          AluSrcB = 2'b10;
        end
        StMemRd: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        StMemWb: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        StMemWr: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        StExec: begin
          AluSrcA = 1'b1;
          AluOp   = 2'b10;
        end
        StRwb: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        StBranch: begin
          AluSrcA     = 1'b1;
          AluOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        StJump: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        StOriEx: begin
          AluSrcA = 1'b1;
          AluSrcB = 2'b10;
          AluOp   = 2'b11;
        end
        StOriWb:  RegWrite = 1'b1;
        StJreg: begin
          PCWrite  = 1'b1;
          PCSource = 2'b11;
        end
        default: ;
      endcase
    end
  end

endmodule
